// File: rtl/bfs_pkg.sv
// Shared constants for the BFS spill queue: default widths and memory FSM state encoding.
package bfs_pkg;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE    = 2'd0;
    localparam mem_state_t ST_WR_REQ  = 2'd1;
    localparam mem_state_t ST_RD_REQ  = 2'd2;
    localparam mem_state_t ST_RD_WAIT = 2'd3;
endpackage

// File: rtl/bfs_spill_queue_if.sv
// Memory request/response port between the spill queue (master) and the memory system (slave).
interface bfs_spill_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/bfs_fifo.sv
// Circular FIFO with a compacting multi-lane push and a single first-word-fall-through pop.
module bfs_fifo #(
    parameter int DEPTH = 4,
    parameter int LANES = 2,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       push,
    input  logic [LANES*W-1:0]     push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   push_n_s;
    logic [AW-1:0] slot_s [LANES];
    logic          pop_s;

    // Each set lane lands at the write pointer plus the number of lower set lanes.
    always_comb begin
        push_n_s = '0;
        for (int i = 0; i < LANES; i++) begin
            slot_s[i] = wr_ptr_r + push_n_s[AW-1:0];
            push_n_s  = push_n_s + (AW+1)'(push[i]);
        end
    end

    assign pop_s = pop & ~empty;
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == '0);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem_r[slot_s[i]] <= push_data[i*W +: W];
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + push_n_s[AW-1:0];
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            count_r  <= count_r + push_n_s - (AW+1)'(pop_s);
        end
    end
endmodule

// File: rtl/bfs_spill_queue_chk.sv
// Protocol and invariant assertions for the BFS spill queue.
module bfs_spill_queue_chk #(
    parameter int ENQ_LANES = 2
) (
    input logic                 clk,
    input logic                 rst,
    input logic [ENQ_LANES-1:0] enqueue_req,
    input logic                 queue_full,
    input logic                 out_full,
    input logic                 bypass,
    input logic                 refill
);
    // Enqueueing while full loses data; the two main-queue feeders never coincide.
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst) !(queue_full && (|enqueue_req)));
    a_xfer_exclusive:   assert property (@(posedge clk) disable iff (rst) !(bypass && refill));
    a_full_flag:        assert property (@(posedge clk) disable iff (rst) out_full |-> queue_full);
endmodule

// File: rtl/bfs_spill_queue.sv
// BFS frontier queue: main queue backed by an out-buffer, a memory spill ring and an in-buffer, FIFO order kept.
module bfs_spill_queue
    import bfs_pkg::*;
#(
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              ENQ_LANES   = 2,
    parameter int              MAINQ_SIZE  = 128,
    parameter int              BUFQ_SIZE   = 64,
    parameter int              SPILL_DEPTH = 4096,
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] SPILL_BASE = {ADDR_W{1'b0}}
) (
    input  logic                        clk,
    input  logic                        bfs_rst,
    input  logic [ENQ_LANES-1:0]        enqueue_req,
    input  logic [ENQ_LANES*DATA_W-1:0] wdata_in,
    input  logic                        dequeue_req,
    output logic [DATA_W-1:0]           rdata_out,
    output logic                        queue_full,
    output logic                        queue_empty,
    output logic                        frontier_empty,
    bfs_spill_queue_if.master           mem
);
    localparam int MW = $clog2(MAINQ_SIZE);
    localparam int BW = $clog2(BUFQ_SIZE);
    localparam int RW = $clog2(SPILL_DEPTH);
    localparam int LW = $clog2(ENQ_LANES + 1);

    logic [MW:0] main_count_s;
    logic [BW:0] out_count_s, in_count_s;
    logic main_full_s, main_empty_s, out_full_s, out_empty_s, in_full_s, in_empty_s;
    logic [DATA_W-1:0] out_head_s, in_head_s, xfer_data_s;
    logic [ENQ_LANES-1:0] main_push_s, out_push_s;
    logic [ENQ_LANES*DATA_W-1:0] main_data_s;
    logic [LW-1:0] enq_n_s;
    logic to_main_s, to_out_s, in_flight_s, bypass_s, refill_s, drained_s;
    logic wr_hs_s, rd_hs_s, rd_start_s, wr_start_s, in_push_s;

    mem_state_t    state_r, state_nxt_s;
    logic          spilled_r;
    logic [RW-1:0] wr_ptr_r, rd_ptr_r;
    logic [RW:0]   ring_count_r;

    // Number of valid lanes this cycle.
    always_comb begin
        enq_n_s = '0;
        for (int i = 0; i < ENQ_LANES; i++) begin
            enq_n_s = enq_n_s + LW'(enqueue_req[i]);
        end
    end

    // Routing sees only registered occupancy, so a same-cycle pop earns no credit.
    assign to_main_s  = (|enqueue_req) & ~spilled_r & (int'(main_count_s) + int'(enq_n_s) <= MAINQ_SIZE);
    assign to_out_s   = (|enqueue_req) & ~to_main_s;
    assign out_push_s = (to_out_s && (int'(out_count_s) + int'(enq_n_s) <= BUFQ_SIZE)) ? enqueue_req : '0;

    assign in_flight_s = (state_r == ST_RD_WAIT);
    assign drained_s   = out_empty_s & in_empty_s & (ring_count_r == '0) & ~in_flight_s;
    // A pending write owns the out-buffer head, so bypass waits for it.
    assign bypass_s    = ~out_empty_s & ~main_full_s & in_empty_s & (ring_count_r == '0) & ~in_flight_s & (state_r != ST_WR_REQ);
    assign refill_s    = ~in_empty_s & ~main_full_s;
    assign xfer_data_s = bypass_s ? out_head_s : in_head_s;

    // Main queue is fed either by the core lanes or by one transferred word.
    always_comb begin
        main_push_s = '0;
        main_data_s = '0;
        if (to_main_s) begin
            main_push_s = enqueue_req;
            main_data_s = wdata_in;
        end else begin
            main_push_s[0]            = bypass_s | refill_s;
            main_data_s[DATA_W-1:0]   = xfer_data_s;
        end
    end

    assign wr_hs_s    = (state_r == ST_WR_REQ) & mem.mem_req_ready;
    assign rd_hs_s    = (state_r == ST_RD_REQ) & mem.mem_req_ready;
    assign in_push_s  = in_flight_s & mem.mem_resp_valid;
    assign rd_start_s = (ring_count_r != '0) & ~in_full_s & (int'(in_count_s) < BUFQ_SIZE / 2);
    assign wr_start_s = ~out_empty_s & (int'(ring_count_r) < SPILL_DEPTH) & ~bypass_s;

    bfs_fifo #(.DEPTH(MAINQ_SIZE), .LANES(ENQ_LANES), .W(DATA_W)) u_main (
        .clk(clk), .rst(bfs_rst), .push(main_push_s), .push_data(main_data_s), .pop(dequeue_req),
        .head(rdata_out), .count(main_count_s), .full(main_full_s), .empty(main_empty_s));

    bfs_fifo #(.DEPTH(BUFQ_SIZE), .LANES(ENQ_LANES), .W(DATA_W)) u_outq (
        .clk(clk), .rst(bfs_rst), .push(out_push_s), .push_data(wdata_in), .pop(bypass_s | wr_hs_s),
        .head(out_head_s), .count(out_count_s), .full(out_full_s), .empty(out_empty_s));

    bfs_fifo #(.DEPTH(BUFQ_SIZE), .LANES(1), .W(DATA_W)) u_inq (
        .clk(clk), .rst(bfs_rst), .push(in_push_s), .push_data(mem.mem_resp_data), .pop(refill_s),
        .head(in_head_s), .count(in_count_s), .full(in_full_s), .empty(in_empty_s));

    // Memory FSM next state; reads take priority so the ring keeps draining.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_start_s)      state_nxt_s = ST_RD_REQ;
                else if (wr_start_s) state_nxt_s = ST_WR_REQ;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_WR_REQ:  state_nxt_s = mem.mem_req_ready  ? ST_IDLE    : ST_WR_REQ;
            ST_RD_REQ:  state_nxt_s = mem.mem_req_ready  ? ST_RD_WAIT : ST_RD_REQ;
            ST_RD_WAIT: state_nxt_s = mem.mem_resp_valid ? ST_IDLE    : ST_RD_WAIT;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM, spill flag and ring pointers.
    always_ff @(posedge clk or posedge bfs_rst) begin
        if (bfs_rst) begin
            state_r      <= ST_IDLE;
            spilled_r    <= 1'b0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            ring_count_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (to_out_s)       spilled_r <= 1'b1;
            else if (drained_s) spilled_r <= 1'b0;
            else                spilled_r <= spilled_r;
            wr_ptr_r     <= wr_ptr_r + RW'(wr_hs_s);
            rd_ptr_r     <= rd_ptr_r + RW'(rd_hs_s);
            ring_count_r <= ring_count_r + (RW+1)'(wr_hs_s) - (RW+1)'(rd_hs_s);
        end
    end

    assign mem.mem_req_valid = (state_r == ST_WR_REQ) | (state_r == ST_RD_REQ);
    assign mem.mem_req_we    = (state_r == ST_WR_REQ);
    assign mem.mem_req_addr  = SPILL_BASE + ADDR_W'((state_r == ST_WR_REQ) ? wr_ptr_r : rd_ptr_r);
    assign mem.mem_req_wdata = out_head_s;

    assign queue_full     = (int'(out_count_s) + ENQ_LANES > BUFQ_SIZE);
    assign queue_empty    = main_empty_s;
    assign frontier_empty = drained_s & main_empty_s;

    bfs_spill_queue_chk #(.ENQ_LANES(ENQ_LANES)) u_chk (
        .clk(clk), .rst(bfs_rst), .enqueue_req(enqueue_req), .queue_full(queue_full),
        .out_full(out_full_s), .bypass(bypass_s), .refill(refill_s));
endmodule

// File: tb/tb_bfs_spill_queue.sv
// Randomized and directed bench for bfs_spill_queue against a queue-level reference model.
module tb_bfs_spill_queue;
    localparam int          DATA_W = 32;
    localparam int          LANES  = 2;
    localparam int          DEPTH  = 8;
    localparam int          ADDR_W = 16;
    localparam logic [15:0] BASE   = 16'h0100;

    logic clk = 1'b0;
    logic bfs_rst;
    logic [LANES-1:0] enqueue_req;
    logic [LANES*DATA_W-1:0] wdata_in;
    logic dequeue_req;
    logic [DATA_W-1:0] rdata_out;
    logic queue_full, queue_empty, frontier_empty;

    bfs_spill_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

    bfs_spill_queue #(.DATA_W(DATA_W), .ENQ_LANES(LANES), .MAINQ_SIZE(4), .BUFQ_SIZE(4),
                      .SPILL_DEPTH(DEPTH), .ADDR_W(ADDR_W), .SPILL_BASE(BASE)) dut (
        .clk(clk), .bfs_rst(bfs_rst), .enqueue_req(enqueue_req), .wdata_in(wdata_in),
        .dequeue_req(dequeue_req), .rdata_out(rdata_out), .queue_full(queue_full),
        .queue_empty(queue_empty), .frontier_empty(frontier_empty), .mem(mem_bus));

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int lat = 3;
    bit rand_lat = 1'b0;
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] deq_log[$];
    logic [DATA_W-1:0] ring_mem [DEPTH];
    int wr_cnt, rd_cnt, hs_cnt;
    bit resp_pend;
    int resp_due;
    logic [DATA_W-1:0] resp_val;
    bit prev_stall;
    logic prev_we;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    logic [DATA_W-1:0] next_id;
    logic [ADDR_W-1:0] first_wr_addr;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        model_q.delete();
        deq_log.delete();
        wr_cnt = 0; rd_cnt = 0; hs_cnt = 0;
        resp_pend = 1'b0; prev_stall = 1'b0;
        next_id = 32'd1;
    endtask

    task automatic do_reset();
        bfs_rst = 1'b1;
        enqueue_req = '0; dequeue_req = 1'b0;
        mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_data = '0; mem_bus.mem_req_ready = 1'b0;
        #2;
        check("rst_queue_empty", 64'(queue_empty), 64'd1);
        check("rst_frontier_empty", 64'(frontier_empty), 64'd1);
        check("rst_queue_full", 64'(queue_full), 64'd0);
        check("rst_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        @(posedge clk); #1;
        bfs_rst = 1'b0;
        model_clear();
    endtask

    task automatic drive_enq(logic [LANES-1:0] mask_in);
        logic [LANES-1:0] mask;
        mask = queue_full ? '0 : mask_in;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                wdata_in[i*DATA_W +: DATA_W] = next_id;
                next_id = next_id + 32'd1;
            end else begin
                wdata_in[i*DATA_W +: DATA_W] = $urandom;
            end
        end
        enqueue_req = mask;
    endtask

    // One clock: compare against the model before the edge, then advance model and memory responder.
    task automatic cycle();
        logic [DATA_W-1:0] exp_v;
        check("frontier_empty", 64'(frontier_empty), 64'(model_q.size() == 0));
        if (dequeue_req && !queue_empty) begin
            if (model_q.size() == 0) begin
                check("deq_unexpected", 64'(queue_empty), 64'd1);
            end else begin
                exp_v = model_q.pop_front();
                check("rdata_out", 64'(rdata_out), 64'(exp_v));
                deq_log.push_back(rdata_out);
            end
        end
        if (prev_stall) begin
            check("hold_valid", 64'(mem_bus.mem_req_valid), 64'd1);
            check("hold_we", 64'(mem_bus.mem_req_we), 64'(prev_we));
            check("hold_addr", 64'(mem_bus.mem_req_addr), 64'(prev_addr));
            if (prev_we) check("hold_wdata", 64'(mem_bus.mem_req_wdata), 64'(prev_wdata));
        end
        if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
            hs_cnt++;
            if (mem_bus.mem_req_we) begin
                if (wr_cnt == 0) first_wr_addr = mem_bus.mem_req_addr;
                check("wr_addr", 64'(mem_bus.mem_req_addr), 64'(BASE + 16'(wr_cnt % DEPTH)));
                check("ring_room", 64'(wr_cnt - rd_cnt < DEPTH), 64'd1);
                ring_mem[wr_cnt % DEPTH] = mem_bus.mem_req_wdata;
                wr_cnt++;
            end else begin
                check("rd_addr", 64'(mem_bus.mem_req_addr), 64'(BASE + 16'(rd_cnt % DEPTH)));
                check("rd_single", 64'(resp_pend), 64'd0);
                resp_pend = 1'b1;
                resp_due  = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
                resp_val  = ring_mem[rd_cnt % DEPTH];
                rd_cnt++;
            end
        end
        prev_stall = mem_bus.mem_req_valid & ~mem_bus.mem_req_ready;
        prev_we    = mem_bus.mem_req_we;
        prev_addr  = mem_bus.mem_req_addr;
        prev_wdata = mem_bus.mem_req_wdata;
        for (int i = 0; i < LANES; i++) begin
            if (enqueue_req[i]) model_q.push_back(wdata_in[i*DATA_W +: DATA_W]);
        end
        @(posedge clk); #1;
        cyc++;
        if (resp_pend && cyc >= resp_due) begin
            mem_bus.mem_resp_valid = 1'b1;
            mem_bus.mem_resp_data  = resp_val;
            resp_pend = 1'b0;
        end else begin
            mem_bus.mem_resp_valid = 1'b0;
            mem_bus.mem_resp_data  = $urandom;
        end
    endtask

    task automatic drain(int budget);
        enqueue_req = '0;
        dequeue_req = 1'b1;
        mem_bus.mem_req_ready = 1'b1;
        for (int i = 0; i < budget && model_q.size() > 0; i++) cycle();
        dequeue_req = 1'b0;
        check("drain_done", 64'(model_q.size()), 64'd0);
        cycle();
        cycle();
    endtask

    task automatic check_log_seq(string name, logic [DATA_W-1:0] first, int n);
        logic [DATA_W-1:0] e;
        check({name, "_len"}, 64'(deq_log.size()), 64'(n));
        for (int i = 0; i < n && i < deq_log.size(); i++) begin
            e = first + DATA_W'(i);
            check(name, 64'(deq_log[i]), 64'(e));
        end
    endtask

    initial begin
        // Reset state.
        do_reset();

        // 1: four words through the main queue only.
        mem_bus.mem_req_ready = 1'b1;
        drive_enq(2'b11); cycle();
        drive_enq(2'b11); cycle();
        enqueue_req = '0;
        dequeue_req = 1'b1;
        repeat (4) cycle();
        dequeue_req = 1'b0;
        cycle();
        check_log_seq("t1_order", 32'd1, 4);
        check("t1_no_mem", 64'(hs_cnt), 64'd0);
        check("t1_frontier", 64'(frontier_empty), 64'd1);

        // 2: overflow with concurrent draining exercises the bypass path.
        deq_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive_enq(2'b11);
            dequeue_req = (i >= 2);
            cycle();
        end
        drain(100);
        check_log_seq("t2_order", 32'd5, 8);

        // 3: sixteen words with spill through memory, latency 3.
        do_reset();
        mem_bus.mem_req_ready = 1'b1;
        lat = 3;
        for (int i = 0; i < 200 && next_id <= 32'd16; i++) begin
            drive_enq(2'b11);
            cycle();
        end
        enqueue_req = '0;
        repeat (10) cycle();
        check("t3_first_wr_addr", 64'(first_wr_addr), 64'h0100);
        drain(300);
        check_log_seq("t3_order", 32'd1, 16);

        // 4: memory stalled; out-buffer backs up to full, request held steady.
        do_reset();
        mem_bus.mem_req_ready = 1'b0;
        repeat (3) begin drive_enq(2'b11); cycle(); end
        check("t4_not_full", 64'(queue_full), 64'd0);
        drive_enq(2'b11); cycle();
        enqueue_req = '0;
        check("t4_full", 64'(queue_full), 64'd1);
        check("t4_req_valid", 64'(mem_bus.mem_req_valid), 64'd1);
        check("t4_req_we", 64'(mem_bus.mem_req_we), 64'd1);
        check("t4_req_addr", 64'(mem_bus.mem_req_addr), 64'h0100);
        check("t4_req_wdata", 64'(mem_bus.mem_req_wdata), 64'd5);
        repeat (6) cycle();
        drain(200);
        check_log_seq("t4_order", 32'd1, 8);

        // 5: fill the ring, then drain across the pointer wrap.
        do_reset();
        mem_bus.mem_req_ready = 1'b1;
        lat = 2;
        for (int i = 0; i < 150; i++) begin
            drive_enq(2'b11);
            cycle();
        end
        enqueue_req = '0;
        repeat (10) cycle();
        check("t5_writes", 64'(wr_cnt), 64'd10);
        check("t5_reads", 64'(rd_cnt), 64'd2);
        check("t5_idle", 64'(mem_bus.mem_req_valid), 64'd0);
        check("t5_full", 64'(queue_full), 64'd1);
        drain(400);
        check_log_seq("t5_order", 32'd1, int'(next_id) - 1);

        // 6: reset while a read is outstanding, then a stale response.
        do_reset();
        mem_bus.mem_req_ready = 1'b1;
        lat = 30;
        for (int i = 0; i < 40 && rd_cnt == 0; i++) begin
            drive_enq(2'b11);
            cycle();
        end
        enqueue_req = '0;
        check("t6_read_issued", 64'(rd_cnt), 64'd1);
        repeat (3) cycle();
        bfs_rst = 1'b1;
        #2;
        check("t6_rst_queue_empty", 64'(queue_empty), 64'd1);
        check("t6_rst_frontier", 64'(frontier_empty), 64'd1);
        check("t6_rst_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        @(posedge clk); #1;
        bfs_rst = 1'b0;
        model_clear();
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = 32'hDEAD_BEEF;
        cycle();
        check("t6_stale_queue_empty", 64'(queue_empty), 64'd1);
        check("t6_stale_frontier", 64'(frontier_empty), 64'd1);
        check("t6_stale_full", 64'(queue_full), 64'd0);
        check("t6_stale_req", 64'(mem_bus.mem_req_valid), 64'd0);
        drive_enq(2'b11); cycle();
        drain(50);
        check_log_seq("t6_order", 32'd1, 2);

        // 7: random traffic with random readiness and latency.
        do_reset();
        rand_lat = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            drive_enq(2'($urandom_range(0, 3)));
            dequeue_req = ($urandom_range(0, 9) < 5);
            mem_bus.mem_req_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain(2000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
